// File: rtl/aes_block_fifo.sv
// aes_block_fifo: DEPTH-entry valid/ready FIFO for AES blocks with occupancy and sync flush.
// The read data comes combinationally from registered storage, so there is no bypass when empty.
module aes_block_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             push, pop;

    // Acceptance looks only at registered full, never at out_ready.
    always_comb begin
        push    = in_valid & ~full_q;
        pop     = out_ready & ~empty_q;
        wr_d    = flush ? '0 : wr_q + AW'(push);
        rd_d    = flush ? '0 : rd_q + AW'(pop);
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
        full_d  = count_d == CW'(DEPTH);
        empty_d = count_d == '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push && !flush) mem_q[wr_q] <= in_data;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign in_ready  = ~full_q;
    assign out_valid = ~empty_q;
    assign out_data  = mem_q[rd_q];
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
endmodule
